pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch-sequencing stage sitting directly upstream of the instruction memory in the single-cycle RISC-V core. Holds the byte PC, chooses the next PC from sequential, branch, or jump sources, and drives the word index into the instruction memory's combinational read port. A small state machine gates fetch validity after reset, on halt, and on an illegal fetch target.

## Interface
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset; must be word-aligned.
- `IMEM_DEPTH`, 64: instruction-memory depth in words; legal PCs are 0 .. 4*IMEM_DEPTH-4.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `stall` in 1: hold PC this cycle.
- `branch_taken` in 1: redirect to `branch_target`.
- `branch_target` in 32: byte address.
- `jump` in 1: redirect to `jump_target` (JAL/JALR).
- `jump_target` in 32: byte address.
- `halt` in 1: stop fetching (ECALL/EBREAK decode).
- `pc` out 32: current byte PC (register).
- `pc_plus4` out 32: `pc + 4`, modulo 2^32.
- `imem_addr` out 32: `{2'b00, pc[31:2]}`, word index into instruction memory.
- `fetch_valid` out 1: the instruction at `imem_addr` is to be executed this cycle.
- `fault` out 1: sticky illegal-target flag.
- `fault_addr` out 32: offending target captured on fault entry.
- `fetch_count` out 32: fetched-instruction counter (see Configuration).

## Operation
- States: BOOT, RUN, HALTED, FAULT.
- BOOT: `fetch_valid=0`, PC held at `RESET_PC`; next edge → RUN unconditionally (inputs ignored).
- RUN: `fetch_valid=1`. Next-PC priority on each edge:
  1. `halt=1` → HALTED, PC unchanged (takes precedence over everything, including stall).
  2. `stall=1` → PC unchanged; `jump`/`branch_taken` ignored this cycle.
  3. `jump=1` → candidate = `jump_target` (jump wins over simultaneous branch).
  4. `branch_taken=1` → candidate = `branch_target`.
  5. otherwise candidate = `pc_plus4`.
- Candidate check (cases 3-5): if `candidate[1:0]!=0` or `candidate >= 4*IMEM_DEPTH` → FAULT, `fault=1`, `fault_addr=candidate`, PC unchanged; else PC ← candidate.
- Sequential fall-off past the last word (`pc = 4*IMEM_DEPTH-4`, no redirect) is a fault with `fault_addr = 4*IMEM_DEPTH`.
- HALTED, FAULT: `fetch_valid=0`, PC, `fault`, and `fault_addr` frozen; exit only via reset.
- `pc_plus4` and `imem_addr` are combinational from `pc`. Wrap of `pc+4` at 2^32 is modular, and the resulting address is caught by the range check.

## Timing
- Reset (async assert): `pc=RESET_PC`, state BOOT, `fetch_valid=0`, `fault=0`, `fault_addr=0`, `fetch_count=0`; `pc_plus4=RESET_PC+4`, `imem_addr=RESET_PC>>2`.
- Reset deassertion is seen at the next rising edge. The first edge enters RUN, so the first `fetch_valid=1` cycle is cycle 1 after release, at `RESET_PC`.
- PC update latency: 1 edge. A redirect asserted in cycle N makes `pc=target` in cycle N+1. No delay slot: the cycle-N instruction is still valid.
- Instruction memory read is combinational, so the instruction for `pc` is available in the same cycle.
- `halt` in cycle N: the cycle-N instruction is valid, and `fetch_valid=0` from N+1.
- Reset asserted mid-RUN/HALTED/FAULT forces the full reset values immediately, independent of `clk`.

## Configuration
- `FETCH_COUNT_EN` defined: `fetch_count` increments on every edge where state=RUN, `halt=0`, and `stall=0` (counts consumed instructions, including the one that faults), wrapping modulo 2^32.
- `FETCH_COUNT_EN` undefined: no counter register; `fetch_count` tied to 0. The port list is identical either way.

## Test plan
- Reset release, idle inputs → cycle 0 `fetch_valid=0 pc=0`; cycles 1,2,3 `pc=0,4,8`, `imem_addr=0,1,2`, `fetch_valid=1`.
- `stall=1` for 3 cycles at `pc=8` with `branch_taken=1 branch_target=40` → `pc` stays 8; after release with no redirect, `pc=12`.
- Simultaneous `jump=1 jump_target=100`, `branch_taken=1 branch_target=20` at `pc=16` → next `pc=100`. Then `branch_taken=1 branch_target=4` → next `pc=4`.
- `branch_target=0x22` (misaligned) → FAULT, `fault=1`, `fault_addr=0x22`, `fetch_valid=0`, PC held. Repeat with `jump_target=256` (IMEM_DEPTH=64) → `fault_addr=256`.
- `halt=1` at `pc=24` → `fetch_valid=0` from next cycle, `pc=24` frozen. Async `reset=0` mid-cycle → `pc=0`, BOOT, `fault=0` immediately.
- With `FETCH_COUNT_EN`: 10 RUN cycles including 2 stalls → `fetch_count=8`. Without the macro → `fetch_count=0` throughout.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus between the core (master) and pc_fetch_unit (slave):
// redirect/control requests inward, PC and fetch status outward.
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, halt,
    input  pc, pc_plus4, imem_addr, fetch_valid, fault, fault_addr, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, halt,
    output pc, pc_plus4, imem_addr, fetch_valid, fault, fault_addr, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-PC selection with BOOT/RUN/HALTED/FAULT fetch gating.
// Optional macro FETCH_COUNT_EN adds a consumed-instruction counter on fetch_count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] pc_plus4;
  logic [31:0] candidate;
  logic        target_bad;

  assign pc_plus4 = pc_q + 32'd4;

  // Jump beats branch; sequential fall-off and wrap are caught by the range test.
  always_comb begin
    candidate = pc_plus4;
    if (bus.jump) begin
      candidate = bus.jump_target;
    end else if (bus.branch_taken) begin
      candidate = bus.branch_target;
    end
  end

  assign target_bad = (candidate[1:0] != 2'b00) || (candidate >= PC_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (!bus.stall) begin
          if (target_bad) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = candidate;
          end else begin
            pc_d = candidate;
          end
        end
      end
      HALTED, FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    bus.fetch_valid = (state_q == RUN);
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_plus4;
    bus.imem_addr   = {2'b00, pc_q[31:2]};
    bus.fault       = fault_q;
    bus.fault_addr  = fault_addr_q;
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // The faulting instruction was consumed too, so it is counted.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if ((state_q == RUN) && !bus.halt && !bus.stall) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit against a behavioural fetch model;
// honours FETCH_COUNT_EN the same way the design does.
module tb_pc_fetch_unit;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
`ifdef FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: booted/stopped flags rather than a state machine.
  logic [31:0] m_pc;
  logic [31:0] m_faddr;
  logic [31:0] m_count;
  bit          m_booted;
  bit          m_stopped;
  bit          m_fault;

  function automatic void model_reset();
    m_pc      = 32'd0;
    m_faddr   = 32'd0;
    m_count   = 32'd0;
    m_booted  = 1'b0;
    m_stopped = 1'b0;
    m_fault   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] target;
    if (!m_booted) begin
      m_booted = 1'b1;
      return;
    end
    if (m_stopped) return;
    if (bus.halt) begin
      m_stopped = 1'b1;
      return;
    end
    if (bus.stall) return;
    if (CNT_EN) m_count = m_count + 32'd1;
    if (bus.jump) target = bus.jump_target;
    else if (bus.branch_taken) target = bus.branch_target;
    else target = m_pc + 32'd4;
    if ((target % 4 != 0) || (target >= LIMIT)) begin
      m_stopped = 1'b1;
      m_fault   = 1'b1;
      m_faddr   = target;
    end else begin
      m_pc = target;
    end
  endfunction

  function automatic logic [161:0] model_vec();
    return {m_pc, m_pc + 32'd4, m_pc >> 2, (m_booted && !m_stopped),
            m_fault, m_faddr, m_count};
  endfunction

  function automatic logic [161:0] dut_vec();
    return {bus.pc, bus.pc_plus4, bus.imem_addr, bus.fetch_valid,
            bus.fault, bus.fault_addr, bus.fetch_count};
  endfunction

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'd0;
    bus.halt          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
    end
    checks++;
    if ({bus.fetch_valid, bus.pc, bus.pc_plus4, bus.imem_addr, bus.fault, bus.fault_addr, bus.fetch_count}
        !== {1'b0, 32'd0, 32'd4, 32'd0, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("[TB] FAIL reset_consts got valid=%b pc=%h p4=%h ia=%h fault=%b fa=%h cnt=%h exp 0/0/4/0/0/0/0",
               bus.fetch_valid, bus.pc, bus.pc_plus4, bus.imem_addr, bus.fault, bus.fault_addr, bus.fetch_count);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++;
      if ({bus.fetch_valid, bus.pc, bus.imem_addr} !== {1'b1, 32'((i - 1) * 4), 32'(i - 1)}) begin
        failures++;
        $display("[TB] FAIL seq_cycle%0d got valid=%b pc=%h ia=%h exp valid=1 pc=%h ia=%h",
                 i, bus.fetch_valid, bus.pc, bus.imem_addr, 32'((i - 1) * 4), 32'(i - 1));
      end
    end
  endtask

  task automatic test_stall();
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd40;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({bus.pc, bus.fetch_valid} !== {32'd8, 1'b1}) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d got pc=%h valid=%b exp pc=8 valid=1", i, bus.pc, bus.fetch_valid);
      end
    end
    idle_inputs();
    cycle();
    checks++;
    if (dut_vec() !== model_vec() || bus.pc !== 32'd12) begin
      failures++;
      $display("[TB] FAIL stall_release got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_jump_priority();
    cycle();
    bus.jump          = 1'b1;
    bus.jump_target   = 32'd100;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd20;
    cycle();
    checks++;
    if (bus.pc !== 32'd100 || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL jump_over_branch got pc=%h exp pc=%h", bus.pc, 32'd100);
    end
    bus.jump          = 1'b0;
    bus.branch_target = 32'd4;
    cycle();
    checks++;
    if (bus.pc !== 32'd4 || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL branch_redirect got pc=%h exp pc=%h", bus.pc, 32'd4);
    end
    idle_inputs();
  endtask

  task automatic test_fault_misaligned();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h22;
    cycle();
    checks++;
    if ({bus.fault, bus.fault_addr, bus.fetch_valid, bus.pc} !== {1'b1, 32'h22, 1'b0, 32'd4}) begin
      failures++;
      $display("[TB] FAIL misaligned_fault got fault=%b fa=%h valid=%b pc=%h exp 1/22/0/4",
               bus.fault, bus.fault_addr, bus.fetch_valid, bus.pc);
    end
    for (int i = 0; i < 3; i++) begin
      bus.jump        = 1'b1;
      bus.jump_target = 32'($urandom_range(0, 60)) << 2;
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL fault_frozen%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    // Out-of-range jump from a freshly reset core.
    do_reset();
    cycle();
    bus.jump        = 1'b1;
    bus.jump_target = 32'd256;
    cycle();
    checks++;
    if ({bus.fault, bus.fault_addr, bus.fetch_valid, bus.pc} !== {1'b1, 32'd256, 1'b0, 32'd0}) begin
      failures++;
      $display("[TB] FAIL range_fault got fault=%b fa=%h valid=%b pc=%h exp 1/100/0/0",
               bus.fault, bus.fault_addr, bus.fetch_valid, bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_fall_off();
    do_reset();
    cycle();
    bus.jump        = 1'b1;
    bus.jump_target = LIMIT - 32'd4;
    cycle();
    idle_inputs();
    checks++;
    if (bus.pc !== 32'd252 || bus.fetch_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL last_word got pc=%h valid=%b exp pc=fc valid=1", bus.pc, bus.fetch_valid);
    end
    cycle();
    checks++;
    if ({bus.fault, bus.fault_addr, bus.pc} !== {1'b1, 32'd256, 32'd252} || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL fall_off got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_halt();
    do_reset();
    cycle();
    bus.jump        = 1'b1;
    bus.jump_target = 32'd24;
    cycle();
    bus.jump  = 1'b0;
    bus.halt  = 1'b1;
    bus.stall = 1'b1;
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'd24) begin
      failures++;
      $display("[TB] FAIL halt_cycle_valid got valid=%b pc=%h exp valid=1 pc=18", bus.fetch_valid, bus.pc);
    end
    cycle();
    idle_inputs();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd40;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({bus.fetch_valid, bus.pc, bus.fault} !== {1'b0, 32'd24, 1'b0} || dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL halt_frozen%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h31;
    cycle();
    idle_inputs();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.pc, bus.fetch_valid, bus.fault, bus.fault_addr} !== {32'd0, 1'b0, 1'b0, 32'd0}
        || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    cycle();
    checks++;
    if (dut_vec() !== model_vec() || bus.fetch_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_rerun got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fetch_count();
    logic [31:0] want;
    do_reset();
    cycle();
    for (int i = 0; i < 10; i++) begin
      bus.stall = (i == 3 || i == 7);
      cycle();
    end
    idle_inputs();
    want = CNT_EN ? 32'd8 : 32'd0;
    checks++;
    if (bus.fetch_count !== want || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL fetch_count got=%0d exp=%0d", bus.fetch_count, want);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_stopped && ($urandom_range(0, 5) == 0)) begin
        do_reset();
      end
      bus.stall         = ($urandom_range(0, 5) == 0);
      bus.halt          = ($urandom_range(0, 60) == 0);
      bus.jump          = ($urandom_range(0, 7) == 0);
      bus.branch_taken  = ($urandom_range(0, 5) == 0);
      bus.jump_target   = ($urandom_range(0, 20) == 0) ? $urandom() : (32'($urandom_range(0, 65)) << 2);
      bus.branch_target = ($urandom_range(0, 20) == 0) ? $urandom() : (32'($urandom_range(0, 65)) << 2);
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL random_step%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_jump_priority();
    test_fault_misaligned();
    test_fall_off();
    test_halt();
    test_async_reset();
    test_fetch_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
